// File: rtl/ram_sync_ws.sv
// ram_sync_ws: synchronous RAM with programmable wait states, ready/ack handshake and clear engine
module ram_sync_ws #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int WAIT_STATES = 0,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_x,
  input  logic [DEPTH-1:0] i_addr,
  input  logic             i_enable_x,
  input  logic             i_write_x,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clear_x,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ready,
  output logic             o_ack,
  output logic             o_busy
);
  localparam logic [1:0] CLEAR = 2'd0, IDLE = 2'd1, WAIT = 2'd2;
  localparam logic [7:0] WS = 8'(WAIT_STATES);
  logic [1:0] state;
  logic [7:0] wcnt;
  logic [DEPTH-1:0] ccnt, lat_addr, acc_addr, mem_addr;
  logic lat_write_x, acc_write_x, req, do_acc, mem_we;
  logic [WIDTH-1:0] lat_data, acc_data, mem_wdata;
  logic [WIDTH-1:0] mem [2**DEPTH];
  assign o_ready = state == IDLE;
  assign o_busy = state == CLEAR;
  assign req = o_ready && !i_enable_x;
  assign do_acc = (req && WS == 8'd0) || (state == WAIT && wcnt == 8'd1);
  assign acc_addr = o_ready ? i_addr : lat_addr;
  assign acc_write_x = o_ready ? i_write_x : lat_write_x;
  assign acc_data = o_ready ? i_data : lat_data;
  assign mem_we = i_rst_x && (o_busy || (do_acc && !acc_write_x));
  assign mem_addr = o_busy ? ccnt : acc_addr;
  assign mem_wdata = o_busy ? CLEAR_VALUE : acc_data;
  // single write port shared by the clear sweep and completing writes
  always_ff @(posedge i_clk)
    if (mem_we) mem[mem_addr] <= mem_wdata;
  // state machine, wait/clear counters, request latch and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_x) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      wcnt <= '0;
      ccnt <= '0;
      o_data <= '0;
      o_ack <= 1'b0;
      lat_addr <= '0;
      lat_write_x <= 1'b1;
      lat_data <= '0;
    end else begin
      o_ack <= do_acc;
      if (do_acc && acc_write_x) o_data <= mem[acc_addr];
      if (state == CLEAR) begin
        ccnt <= ccnt + 1'b1;
        if (&ccnt) state <= IDLE;
      end else if (state == WAIT) begin
        wcnt <= wcnt - 1'b1;
        if (wcnt == 8'd1) state <= IDLE;
      end else if (req) begin
        lat_addr <= i_addr;
        lat_write_x <= i_write_x;
        lat_data <= i_data;
        if (WS != 8'd0) begin
          state <= WAIT;
          wcnt <= WS;
        end
      end else if (!i_clear_x) begin
        state <= CLEAR;
        ccnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ram_sync_ws.sv
// tb_ram_sync_ws: randomized self-checking bench for two ram_sync_ws configurations
module tb_ram_sync_ws;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic a_rst_x, a_en_x, a_we_x, a_clr_x, a_rdy, a_ack, a_busy;
  logic [3:0] a_addr;
  logic [7:0] a_din, a_dout;
  logic b_rst_x, b_en_x, b_we_x, b_clr_x, b_rdy, b_ack, b_busy;
  logic [3:0] b_addr;
  logic [15:0] b_din, b_dout;
  logic [7:0] m0 [16];
  logic [15:0] m1 [16];
  logic [7:0] exp0;
  logic [15:0] exp1;
  int checks = 0, errors = 0;

  ram_sync_ws #(.WIDTH(8), .DEPTH(4), .WAIT_STATES(0), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5)) u0 (
    .i_clk(clk), .i_rst_x(a_rst_x), .i_addr(a_addr), .i_enable_x(a_en_x), .i_write_x(a_we_x),
    .i_data(a_din), .i_clear_x(a_clr_x), .o_data(a_dout), .o_ready(a_rdy), .o_ack(a_ack), .o_busy(a_busy));

  ram_sync_ws #(.WIDTH(16), .DEPTH(4), .WAIT_STATES(3), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(16'h0000)) u1 (
    .i_clk(clk), .i_rst_x(b_rst_x), .i_addr(b_addr), .i_enable_x(b_en_x), .i_write_x(b_we_x),
    .i_data(b_din), .i_clear_x(b_clr_x), .o_data(b_dout), .o_ready(b_rdy), .o_ack(b_ack), .o_busy(b_busy));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int n;
    a_rst_x = 0; b_rst_x = 0;
    tick(); tick();
    checks++; if (a_busy !== 1'b1 || a_rdy !== 1'b0) begin errors++; $display("FAIL reset_a_state busy=%b ready=%b exp busy=1 ready=0", a_busy, a_rdy); end
    checks++; if (a_ack !== 1'b0 || a_dout !== 8'h00) begin errors++; $display("FAIL reset_a_out ack=%b data=%h exp 0/00", a_ack, a_dout); end
    checks++; if (b_busy !== 1'b0 || b_rdy !== 1'b1) begin errors++; $display("FAIL reset_b_state busy=%b ready=%b exp busy=0 ready=1", b_busy, b_rdy); end
    checks++; if (b_ack !== 1'b0 || b_dout !== 16'h0000) begin errors++; $display("FAIL reset_b_out ack=%b data=%h exp 0/0000", b_ack, b_dout); end
    a_rst_x = 1; b_rst_x = 1;
    n = 0;
    while (a_busy === 1'b1 && n < 100) begin
      checks++; if (a_rdy !== 1'b0 || a_ack !== 1'b0) begin errors++; $display("FAIL sweep_flags cyc=%0d ready=%b ack=%b exp 0/0", n, a_rdy, a_ack); end
      n++;
      tick();
    end
    checks++; if (n != 16) begin errors++; $display("FAIL sweep_len got %0d exp 16", n); end
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL sweep_ready got %b exp 1", a_rdy); end
    for (int i = 0; i < 16; i++) m0[i] = 8'hA5;
    exp0 = 8'h00; exp1 = 16'h0000;
  endtask

  task automatic test_clear_readback;
    for (int i = 0; i < 16; i++) begin
      a_en_x = 0; a_we_x = 1; a_addr = 4'(i);
      tick();
      exp0 = m0[i];
      checks++; if (a_ack !== 1'b1 || a_dout !== exp0) begin errors++; $display("FAIL clear_read addr=%0d ack=%b data=%h exp 1/%h", i, a_ack, a_dout, exp0); end
    end
    a_en_x = 1;
    tick();
    checks++; if (a_ack !== 1'b0 || a_dout !== exp0) begin errors++; $display("FAIL idle_after_reads ack=%b data=%h exp 0/%h", a_ack, a_dout, exp0); end
  endtask

  task automatic test_ws0_random;
    logic [3:0] ad;
    for (int i = 0; i < 40; i++) begin
      ad = (i < 2) ? 4'hC : 4'($urandom_range(0, 15));
      a_en_x = 0;
      a_we_x = (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      a_addr = ad;
      a_din = (i == 0) ? 8'h3C : 8'($urandom);
      tick();
      if (a_we_x) exp0 = m0[ad]; else m0[ad] = a_din;
      checks++; if (a_ack !== 1'b1 || a_dout !== exp0) begin errors++; $display("FAIL ws0_op i=%0d addr=%0d ack=%b data=%h exp 1/%h", i, ad, a_ack, a_dout, exp0); end
    end
    a_en_x = 1;
    tick();
    checks++; if (a_ack !== 1'b0 || a_rdy !== 1'b1) begin errors++; $display("FAIL ws0_idle ack=%b ready=%b exp 0/1", a_ack, a_rdy); end
  endtask

  task automatic test_ws3;
    logic [3:0] ad;
    logic wr_x;
    logic [15:0] d;
    for (int i = 0; i < 46; i++) begin
      ad = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
      wr_x = (i < 16) ? 1'b0 : 1'($urandom_range(0, 1));
      d = 16'($urandom);
      b_en_x = 0; b_we_x = wr_x; b_addr = ad; b_din = d;
      tick();
      for (int c = 0; c < 3; c++) begin
        checks++; if (b_rdy !== 1'b0 || b_ack !== 1'b0 || b_dout !== exp1) begin errors++; $display("FAIL ws3_wait i=%0d c=%0d ready=%b ack=%b data=%h exp 0/0/%h", i, c, b_rdy, b_ack, b_dout, exp1); end
        b_en_x = 1'($urandom_range(0, 1)); b_we_x = 1'($urandom_range(0, 1));
        b_addr = 4'($urandom); b_din = 16'($urandom); b_clr_x = 1'($urandom_range(0, 1));
        tick();
      end
      if (wr_x) exp1 = m1[ad]; else m1[ad] = d;
      checks++; if (b_ack !== 1'b1 || b_rdy !== 1'b1 || b_dout !== exp1) begin errors++; $display("FAIL ws3_done i=%0d addr=%0d ack=%b ready=%b data=%h exp 1/1/%h", i, ad, b_ack, b_rdy, b_dout, exp1); end
      b_en_x = 1; b_clr_x = 1;
      tick();
      checks++; if (b_ack !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL ws3_after i=%0d ack=%b busy=%b exp 0/0", i, b_ack, b_busy); end
    end
  endtask

  task automatic test_reset_mid_wait;
    b_en_x = 0; b_we_x = 0; b_addr = 4'd5; b_din = ~m1[5];
    tick();
    b_en_x = 1;
    tick();
    b_rst_x = 0;
    tick();
    exp1 = 16'h0000;
    checks++; if (b_ack !== 1'b0 || b_rdy !== 1'b1 || b_busy !== 1'b0 || b_dout !== exp1) begin errors++; $display("FAIL midwait_reset ack=%b ready=%b busy=%b data=%h exp 0/1/0/0000", b_ack, b_rdy, b_busy, b_dout); end
    b_rst_x = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (b_ack !== 1'b0 || b_rdy !== 1'b1) begin errors++; $display("FAIL midwait_quiet c=%0d ack=%b ready=%b exp 0/1", c, b_ack, b_rdy); end
    end
    b_en_x = 0; b_we_x = 1; b_addr = 4'd5;
    tick();
    b_en_x = 1;
    tick(); tick(); tick();
    exp1 = m1[5];
    checks++; if (b_ack !== 1'b1 || b_dout !== exp1) begin errors++; $display("FAIL midwait_mem5 ack=%b data=%h exp 1/%h", b_ack, b_dout, exp1); end
    tick();
  endtask

  task automatic test_clear_request;
    int n;
    a_en_x = 0; a_we_x = 0; a_addr = 4'd7; a_din = 8'h3C; a_clr_x = 0;
    tick();
    m0[7] = 8'h3C;
    checks++; if (a_ack !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL clrreq_access ack=%b busy=%b exp 1/0", a_ack, a_busy); end
    a_en_x = 1;
    tick();
    checks++; if (a_busy !== 1'b1 || a_ack !== 1'b0 || a_rdy !== 1'b0) begin errors++; $display("FAIL clrreq_start busy=%b ack=%b ready=%b exp 1/0/0", a_busy, a_ack, a_rdy); end
    a_clr_x = 1;
    n = 0;
    while (a_busy === 1'b1 && n < 100) begin
      checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL clrreq_ack cyc=%0d got %b exp 0", n, a_ack); end
      n++;
      tick();
    end
    checks++; if (n != 16) begin errors++; $display("FAIL clrreq_len got %0d exp 16", n); end
    for (int i = 0; i < 16; i++) m0[i] = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      a_en_x = 0; a_we_x = 1; a_addr = 4'(15 - i);
      tick();
      exp0 = m0[15 - i];
      checks++; if (a_ack !== 1'b1 || a_dout !== exp0) begin errors++; $display("FAIL clrreq_read addr=%0d ack=%b data=%h exp 1/%h", 15 - i, a_ack, a_dout, exp0); end
    end
    a_en_x = 1;
    tick();
  endtask

  initial begin
    a_rst_x = 0; a_en_x = 1; a_we_x = 1; a_clr_x = 1; a_addr = '0; a_din = '0;
    b_rst_x = 0; b_en_x = 1; b_we_x = 1; b_clr_x = 1; b_addr = '0; b_din = '0;
    test_reset();
    test_clear_readback();
    test_ws0_random();
    test_ws3();
    test_reset_mid_wait();
    test_clear_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
